// File: rtl/wr_resp_return_buffer_if.sv
// Write-response return buffer bus: per-direction push side (no ready) and
// per-direction valid/ready return side, plus afull throttle and overflow flags.
// Ports: v_wresp_vld/pld (push), v_out_vld/rdy/pld (return), v_afull, v_ovf_err.

package wr_resp_pkg;
    typedef struct packed {
        logic [7:0] txnid;
        logic [7:0] sideband;
    } wr_resp_pld_t;
endpackage

interface wr_resp_return_buffer_if #(
    parameter int WIDTH = 4
);
    import wr_resp_pkg::*;

    logic         [WIDTH-1:0] v_wresp_vld;
    wr_resp_pld_t [WIDTH-1:0] v_wresp_pld;
    logic         [WIDTH-1:0] v_out_vld;
    logic         [WIDTH-1:0] v_out_rdy;
    wr_resp_pld_t [WIDTH-1:0] v_out_pld;
    logic         [WIDTH-1:0] v_afull;
    logic         [WIDTH-1:0] v_ovf_err;

    // Buffer side
    modport slave (
        input  v_wresp_vld, v_wresp_pld, v_out_rdy,
        output v_out_vld, v_out_pld, v_afull, v_ovf_err
    );

    // Decoder/master side
    modport master (
        output v_wresp_vld, v_wresp_pld, v_out_rdy,
        input  v_out_vld, v_out_pld, v_afull, v_ovf_err
    );
endinterface

// File: rtl/wr_resp_return_buffer.sv
// Per-direction write-response return buffer: one DEPTH-entry FIFO per lane.
// Latency: 1 cycle push-to-out (0 cycles with WR_RESP_BYPASS_EN defined on an empty lane).
// Backpressure: none upstream (full+push without pop drops and sets sticky v_ovf_err);
// v_afull throttles upstream; return side is valid/ready per lane.
// Ports: clk, rst (async active-high), bus (wr_resp_return_buffer_if.slave).
// Optional macro: WR_RESP_BYPASS_EN.

module wr_resp_return_buffer
    import wr_resp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    wr_resp_return_buffer_if.slave        bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE     = 1;
    localparam logic [PW:0] AFULL_V = AFULL_TH[PW:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]  wr_ptr_q [WIDTH];
    logic [PW:0]  wr_ptr_d [WIDTH];
    logic [PW:0]  rd_ptr_q [WIDTH];
    logic [PW:0]  rd_ptr_d [WIDTH];
    logic [PW:0]  occ      [WIDTH];
    wr_resp_pld_t mem_q    [WIDTH][DEPTH];

    logic [WIDTH-1:0] ovf_q;
    logic [WIDTH-1:0] ovf_d;
    logic [WIDTH-1:0] empty;
    logic [WIDTH-1:0] full;
    logic [WIDTH-1:0] pop;
    logic [WIDTH-1:0] wr_en;

    always_comb begin
        empty         = '0;
        full          = '0;
        pop           = '0;
        wr_en         = '0;
        ovf_d         = ovf_q;
        bus.v_out_vld = '0;
        bus.v_out_pld = '0;
        bus.v_afull   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            occ[i]      = wr_ptr_q[i] - rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]     = (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]) &&
                          (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]);
            bus.v_afull[i] = (occ[i] >= AFULL_V);
`ifdef WR_RESP_BYPASS_EN
            // Empty lane presents the incoming response directly; it is only
            // stored if the master does not take it this cycle.
            bus.v_out_vld[i] = !empty[i] || bus.v_wresp_vld[i];
            bus.v_out_pld[i] = empty[i] ? bus.v_wresp_pld[i] : mem_q[i][rd_ptr_q[i][PW-1:0]];
            pop[i]   = !empty[i] && bus.v_out_rdy[i];
            wr_en[i] = bus.v_wresp_vld[i] && (!full[i] || pop[i]) &&
                       !(empty[i] && bus.v_out_rdy[i]);
`else
            bus.v_out_vld[i] = !empty[i];
            bus.v_out_pld[i] = mem_q[i][rd_ptr_q[i][PW-1:0]];
            pop[i]   = !empty[i] && bus.v_out_rdy[i];
            wr_en[i] = bus.v_wresp_vld[i] && (!full[i] || pop[i]);
`endif
            // A pop in the same cycle frees the slot, so a full lane still accepts.
            if (bus.v_wresp_vld[i] && full[i] && !pop[i]) begin
                ovf_d[i] = 1'b1;
            end
            if (wr_en[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + ONE;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < WIDTH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i][PW-1:0]] <= bus.v_wresp_pld[i];
            end
        end
    end

    assign bus.v_ovf_err = ovf_q;

endmodule
